// File: rtl/lb_pio_in_irq.sv
// lb_pio_in_irq: Avalon-MM input PIO with input synchroniser, per-bit edge capture, irq mask and registered irq
module lb_pio_in_irq #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_MODE    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    output logic              irq
);
    localparam logic [2:0] PRIME_N = 3'(SYNC_STAGES + 1);
    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q, sync_d;
    logic [DATA_W-1:0] sdata, prev_q, edgecap_q, edgecap_d, irqmask_q, irqmask_d;
    logic [DATA_W-1:0] wdata, rise, fall, any_e, edge_det;
    logic [2:0]        prime_q, prime_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              irq_q, irq_d, wr, primed;
    logic              unused_wd;
    assign unused_wd = ^writedata;
    assign wdata     = writedata[DATA_W-1:0];
    assign sdata     = sync_q[SYNC_STAGES-1];
    assign readdata  = readdata_q;
    assign irq       = irq_q;
    // next state: sync shift, priming, edge capture with set-over-clear, mask load, read mux, irq source
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], in_port};
        wr         = chipselect & ~write_n;
        primed     = prime_q == PRIME_N;
        prime_d    = primed ? prime_q : prime_q + 3'd1;
        rise       = sdata & ~prev_q;
        fall       = ~sdata & prev_q;
        any_e      = sdata ^ prev_q;
        edge_det   = !primed ? '0 : EDGE_TYPE == 0 ? rise : EDGE_TYPE == 1 ? fall : any_e;
        edgecap_d  = (edgecap_q & ~((wr && address == 2'd3) ? wdata : '0)) | edge_det;
        irqmask_d  = (wr && address == 2'd1) ? wdata : irqmask_q;
        readdata_d = address == 2'd0 ? 32'(sdata) :
                     address == 2'd1 ? 32'(irqmask_q) :
                     address == 2'd3 ? 32'(edgecap_q) : 32'd0;
        irq_d      = |((IRQ_MODE == 1 ? edgecap_q : sdata) & irqmask_q);
    end
    // state registers, all cleared asynchronously so priming restarts on every reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            prev_q     <= '0;
            prime_q    <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= sdata;
            prime_q    <= prime_d;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end
endmodule

// File: tb/tb_lb_pio_in_irq.sv
// tb_lb_pio_in_irq: directed bench with a due-cycle scoreboard for edge-mode and level-mode PIO instances
module tb_lb_pio_in_irq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  in_port = 8'd0;
    logic [31:0] rd_e, rd_l;
    logic        irq_e, irq_l;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    typedef struct {
        string       tag;
        int          sel;
        int          due;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    lb_pio_in_irq #(.DATA_W(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)) u_edge (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_e), .in_port(in_port), .irq(irq_e));
    lb_pio_in_irq #(.DATA_W(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0)) u_lvl (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_l), .in_port(in_port), .irq(irq_l));

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(int sel);
        return sel == 0 ? rd_e : sel == 1 ? 32'(irq_e) : sel == 2 ? rd_l : 32'(irq_l);
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, o, e);
        end
    endtask

    task automatic push(string tag, int sel, int d, logic [31:0] e);
        sb.push_back('{tag, sel, cyc + d, e});
    endtask

    task automatic step(int n);
        exp_t keep[$];
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            keep = {};
            foreach (sb[i]) begin
                if (sb[i].due <= cyc) chk(sb[i].tag, obs(sb[i].sel), sb[i].exp);
                else keep.push_back(sb[i]);
            end
            sb = keep;
        end
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        step(2);
        chk("rst_rd_e", rd_e, 32'd0);
        chk("rst_irq_e", 32'(irq_e), 32'd0);
        chk("rst_rd_l", rd_l, 32'd0);
        chk("rst_irq_l", 32'(irq_l), 32'd0);
        reset_n = 1'b1;
        step(5);
        // data read latency and rising capture with irq masked off
        in_port = 8'hA5;
        address = 2'd0;
        push("t1_rd_early", 0, 2, 32'h0);
        push("t1_rd", 0, 3, 32'hA5);
        push("t1_rd_hold", 0, 4, 32'hA5);
        step(4);
        address = 2'd3;
        push("t1_cap", 0, 1, 32'hA5);
        push("t1_irq_masked", 1, 1, 32'h0);
        step(1);
        address = 2'd1;
        push("t1_mask", 0, 1, 32'h0);
        step(1);
        wr(2'd2, 32'hFFFF_FFFF);
        address = 2'd2;
        push("t1_rsvd", 0, 1, 32'h0);
        step(1);
        wr(2'd3, 32'hFF);
        in_port = 8'h00;
        address = 2'd3;
        step(6);
        push("t1_clr", 0, 1, 32'h0);
        step(1);
        // edge latency on bit3, then write-one-to-clear
        wr(2'd1, 32'h08);
        address = 2'd1;
        push("t2_mask", 0, 1, 32'h08);
        step(1);
        address = 2'd3;
        in_port = 8'h08;
        push("t2_cap_early", 0, 3, 32'h0);
        push("t2_cap", 0, 4, 32'h08);
        push("t2_irq_early", 1, 3, 32'h0);
        push("t2_irq", 1, 4, 32'h1);
        push("t2_lvl_early", 3, 2, 32'h0);
        push("t2_lvl", 3, 3, 32'h1);
        step(4);
        wr(2'd3, 32'h08);
        chk("t2_irq_hold", 32'(irq_e), 32'h1);
        push("t2_clr_irq", 1, 1, 32'h0);
        push("t2_clr_cap", 0, 1, 32'h0);
        step(1);
        // clear write lands in the same cycle the edge sets: set wins
        in_port = 8'h00;
        step(4);
        in_port = 8'h08;
        step(2);
        wr(2'd3, 32'h08);
        push("t3_cap", 0, 1, 32'h08);
        step(1);
        wr(2'd3, 32'h08);
        in_port = 8'h00;
        step(4);
        // level mode irq follows synchronised data one clock later
        wr(2'd1, 32'h01);
        in_port = 8'h01;
        push("t5_lvl_early", 3, 2, 32'h0);
        push("t5_lvl_hi", 3, 3, 32'h1);
        step(4);
        in_port = 8'h00;
        push("t5_lvl_hold", 3, 2, 32'h1);
        push("t5_lvl_lo", 3, 3, 32'h0);
        step(4);
        wr(2'd3, 32'hFF);
        // mid-operation reset clears everything, no edges reported after release
        wr(2'd1, 32'h0F);
        wr(2'd3, 32'hFF);
        in_port = 8'h0F;
        address = 2'd3;
        push("t6_cap", 0, 5, 32'h0F);
        push("t6_irq", 1, 5, 32'h1);
        push("t6_lvl_irq", 3, 5, 32'h1);
        step(5);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_rd_e", rd_e, 32'h0);
        chk("t6_rst_irq_e", 32'(irq_e), 32'h0);
        chk("t6_rst_rd_l", rd_l, 32'h0);
        chk("t6_rst_irq_l", 32'(irq_l), 32'h0);
        step(2);
        reset_n = 1'b1;
        step(8);
        chk("t6_no_edge", rd_e, 32'h0);
        chk("t6_no_irq", 32'(irq_e), 32'h0);
        address = 2'd1;
        push("t6_mask_rst", 0, 1, 32'h0);
        step(1);
        // level already high through reset release is not an edge
        in_port = 8'hFF;
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        address = 2'd3;
        step(8);
        chk("t4_cap", rd_e, 32'h0);
        chk("t4_irq", 32'(irq_e), 32'h0);
        address = 2'd0;
        push("t4_data", 0, 1, 32'hFF);
        step(1);
        for (int k = 0; k < 20 && sb.size() > 0; k++) step(1);
        foreach (sb[i]) begin
            checks++;
            errors++;
            $error("FAIL %s: never reached, expected %h", sb[i].tag, sb[i].exp);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
